load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Core-side initiator for data memory accesses: takes load/store requests from the RISC-V
//   MEM stage, aligns them to word-addressed memory (byte strobes, lane replication), runs a
//   valid/ready handshake to the data memory, and returns sign/zero-extended load data.
//   Stalls the pipeline while an access is in flight.
// PARAMETERS
//   ADDR_W   32   byte-address width from the ALU result
//   TIMEOUT  255  max cycles in WAIT before bus error (used only with LSU_TIMEOUT_EN)
// PORTS
//   clk         in   1         single clock, rising edge
//   rst_n       in   1         asynchronous, active-low reset
//   req_valid   in   1         core requests an access; held until done
//   req_store   in   1         1 = store, 0 = load
//   req_funct3  in   3         RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr    in   ADDR_W    byte address
//   req_wdata   in   32        store data, right-aligned
//   stall       out  1         req_valid & ~done (combinational)
//   done        out  1         1-cycle pulse: access finished, rdata/err flags valid
//   rdata       out  32        extended load data (0 for stores and errors)
//   misaligned  out  1         with done: H at odd address or W not 4-aligned
//   bus_err     out  1         with done: memory timeout
//   mem_req     out  1         memory request valid
//   mem_we      out  1         write enable
//   mem_addr    out  ADDR_W-2  word address = req_addr[ADDR_W-1:2]
//   mem_wdata   out  32        lane-replicated store data
//   mem_wstrb   out  4         byte enables
//   mem_ready   in   1         memory accepted (store) / rdata valid (load) this cycle
//   mem_rdata   in   32        full word read data
// BEHAVIOUR
//   Reset: state IDLE; mem_req, mem_we, done, misaligned, bus_err = 0; rdata, mem_addr, mem_wdata = 0.
//     mem_wstrb = 0.
//   FSM: IDLE -> WAIT -> DONE -> IDLE.
//   IDLE: on req_valid & aligned, register mem_* outputs and enter WAIT.
//     On req_valid & misaligned, enter DONE with misaligned=1; no mem_req.
//   WAIT: mem_req=1. All mem_* outputs are held stable until mem_ready.
//     On mem_ready: load captures extend(mem_rdata) into rdata; enter DONE.
//   DONE: done=1 for one cycle, req_valid ignored; return to IDLE.
//   Latency: minimum 2 cycles (request accepted at edge N, ready in N+1, done in N+2).
//   Size = funct3[1:0] (00 B, 01 H, 1x W); unsigned = funct3[2].
//   Strobes: B = 0001<<a[1:0]; H = 0011<<a[1:0]; W = 1111.
//   mem_wdata: B -> {4{wdata[7:0]}}, H -> {2{wdata[15:0]}}, W -> wdata.
//   Load extract: select lane by a[1:0]; sign-extend if unsigned=0, else zero-extend.
//   Async reset mid-access drops mem_req immediately; the access is abandoned and no done
//     pulse follows.
//   misaligned/bus_err are mutually exclusive; rdata=0 whenever either is set.
// CONFIGURATION
//   `LSU_TIMEOUT_EN defined: 8+ bit counter clears on WAIT entry and increments each WAIT
//     cycle. If it reaches TIMEOUT without mem_ready: deassert mem_req, enter DONE, bus_err=1.
//     mem_ready on the same cycle as the limit wins (normal completion).
//   Undefined: no counter; WAIT lasts indefinitely; bus_err tied 0.
// STRUCTURE
//   lsu_pkg: funct3 localparams, size encodings, state enum (IDLE/WAIT/DONE), strobe helper.
//   Sub-module lsu_load_align: combinational lane select and extension (mem_rdata, a[1:0],
//     size, unsigned -> 32-bit).
// TESTING
//   SW 0xDEADBEEF @0x10, ready in first WAIT cycle -> mem_addr=4, wstrb=1111, done 2 cycles after req.
//   LB @0x13, mem_rdata=0x80000000 -> rdata=0xFFFFFF80; LBU same -> 0x00000080.
//   SH 0x1234 @0x6 -> wstrb=1100, mem_wdata=0x12341234; LHU @0x2, rdata 0xABCD0000 -> 0x0000ABCD.
//   LH @0x5 -> done+misaligned at next edge, mem_req never high, rdata=0.
//   LW, mem_ready delayed 3 cycles -> mem_addr/mem_req stable, stall=1 throughout,
//     done one cycle after ready.
//   TIMEOUT=4 with macro, ready never -> bus_err+done after 4 WAIT cycles.
//     rst_n low during WAIT -> mem_req=0 at once and no done.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, access-size
// encodings, the FSM state type and small alignment helpers.
package lsu_pkg;

   // RISC-V load/store funct3 codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Access size is funct3[1:0]; 2'b11 is treated as a word
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } lsu_state_e;

   // Byte enables for an access of the given size at byte offset off
   function automatic logic [3:0] lsu_strobe(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] s;
      case (size)
         SZ_B:    s = 4'b0001 << off;
         SZ_H:    s = 4'b0011 << off;
         default: s = 4'b1111;
      endcase
      return s;
   endfunction

   // Halfwords need an even address, words a 4-aligned address
   function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic m;
      case (size)
         SZ_B:    m = 1'b0;
         SZ_H:    m = off[0];
         default: m = (off != 2'b00);
      endcase
      return m;
   endfunction

   // Replicate right-aligned store data across every lane it could land in
   function automatic logic [31:0] lsu_replicate(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] r;
      case (size)
         SZ_B:    r = {4{wdata[7:0]}};
         SZ_H:    r = {2{wdata[15:0]}};
         default: r = wdata;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/halfword lane out of a full
// memory word and sign- or zero-extends it to 32 bits. Purely combinational.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select followed by extension to the full register width
   always_comb begin
      byte_sel = mem_rdata[7:0];
      case (off)
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         2'd3:    byte_sel = mem_rdata[31:24];
         default: byte_sel = mem_rdata[7:0];
      endcase
      half_sel = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

      data = mem_rdata;
      case (size)
         SZ_B:    data = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         SZ_H:    data = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: data = mem_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts MEM-stage requests, drives a word-addressed
// valid/ready data memory port with byte strobes and replicated store data,
// and returns extended load data with a one-cycle done pulse.
// Optional feature macro: LSU_TIMEOUT_EN (adds a WAIT watchdog that
// reports bus_err after TIMEOUT cycles without mem_ready).
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              misaligned,
   output logic              bus_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata
);

   lsu_state_e        state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_wstrb_q, mem_wstrb_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;
   logic              done_q, done_d;
   logic              misaligned_q, misaligned_d;
   logic              bus_err_q, bus_err_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [1:0]        req_size;
   logic [31:0]       load_data;
   logic              timeout_hit;

   assign req_size = req_funct3[1:0];

   // Extraction works from the registered request so it is stable across WAIT
   lsu_load_align u_load_align (
      .mem_rdata   (mem_rdata),
      .off         (off_q),
      .size        (f3_q[1:0]),
      .is_unsigned (f3_q[2]),
      .data        (load_data)
   );

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Watchdog: cleared while idle (so it starts at zero on WAIT entry), counts WAIT cycles
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_IDLE)
         cnt_d = '0;
      else if (state_q == S_WAIT)
         cnt_d = cnt_q + 1'b1;
   end

   // Watchdog counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   // Fires in the last permitted WAIT cycle; mem_ready in that cycle still wins
   assign timeout_hit = (state_q == S_WAIT) && (cnt_q == CNT_LAST);
`else
   // No watchdog: WAIT lasts until mem_ready (TIMEOUT only sizes the optional counter)
   assign timeout_hit = 1'b0 & (TIMEOUT != 0);
`endif

   // Next-state and registered-output computation for the IDLE/WAIT/DONE sequence
   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wstrb_d  = mem_wstrb_q;
      f3_d         = f3_q;
      off_d        = off_q;
      done_d       = 1'b0;
      misaligned_d = 1'b0;
      bus_err_d    = 1'b0;
      rdata_d      = '0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (lsu_misaligned(req_size, req_addr[1:0])) begin
                  // Never reaches the bus: report straight away
                  state_d      = S_DONE;
                  done_d       = 1'b1;
                  misaligned_d = 1'b1;
               end else begin
                  state_d     = S_WAIT;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_store;
                  mem_addr_d  = req_addr[ADDR_W-1:2];
                  mem_wdata_d = lsu_replicate(req_size, req_wdata);
                  mem_wstrb_d = lsu_strobe(req_size, req_addr[1:0]);
                  f3_d        = req_funct3;
                  off_d       = req_addr[1:0];
               end
            end
         end
         S_WAIT: begin
            if (mem_ready) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (!mem_we_q)
                  rdata_d = load_data;
            end else if (timeout_hit) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               bus_err_d = 1'b1;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end
         S_DONE: begin
            // done is high this cycle; the held request is ignored
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset abandons any access in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wstrb_q  <= '0;
         f3_q         <= '0;
         off_q        <= '0;
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
         bus_err_q    <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wstrb_q  <= mem_wstrb_d;
         f3_q         <= f3_d;
         off_q        <= off_d;
         done_q       <= done_d;
         misaligned_q <= misaligned_d;
         bus_err_q    <= bus_err_d;
         rdata_q      <= rdata_d;
      end
   end

   assign stall      = req_valid & ~done_q;
   assign done       = done_q;
   assign rdata      = rdata_q;
   assign misaligned = misaligned_q;
   assign bus_err    = bus_err_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses checked against an arithmetic reference model.
// With LSU_TIMEOUT_EN defined the DUT is built with TIMEOUT=4 and the
// bus-error path is exercised as well.
module tb_load_store_unit;
   import lsu_pkg::*;

`ifdef LSU_TIMEOUT_EN
   localparam int TB_TIMEOUT = 4;
`else
   localparam int TB_TIMEOUT = 255;
`endif

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        done;
   logic [31:0] rdata;
   logic        misaligned;
   logic        bus_err;
   logic        mem_req;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   load_store_unit #(.ADDR_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_store  (req_store),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .done       (done),
      .rdata      (rdata),
      .misaligned (misaligned),
      .bus_err    (bus_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: access width in bytes from funct3
   function automatic int nbytes(input logic [2:0] f3);
      if (f3[1:0] == 2'b00)      return 1;
      else if (f3[1:0] == 2'b01) return 2;
      else                       return 4;
   endfunction

   // Reference model: expected extended load value from a memory word
   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] word);
      int n;
      int off;
      logic [31:0] v;
      logic [31:0] lim;
      n   = nbytes(f3);
      off = int'(addr % 4);
      v   = word >> (8 * off);
      if (n < 4) begin
         lim = 32'd1 << (8 * n);
         v   = v % lim;
         if (!f3[2] && (v >= (lim / 2)))
            v = v - lim;
      end
      return v;
   endfunction

   // One complete access: drives the request, plays memory with the given
   // ready delay, and checks bus-side outputs and the completion.
   task automatic run_access(input string tag, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rw, input int delay);
      int          n;
      bit          mis;
      logic [3:0]  exp_strb;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
      n         = nbytes(f3);
      mis       = (addr % n) != 0;
      exp_strb  = 4'(((1 << n) - 1) << (addr % 4));
      if (n == 1)      exp_wdata = {24'b0, wd[7:0]} * 32'h01010101;
      else if (n == 2) exp_wdata = {16'b0, wd[15:0]} * 32'h00010001;
      else             exp_wdata = wd;
      exp_rdata = (st || mis) ? 32'h0 : model_load(f3, addr, rw);

      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      mem_ready  = 1'b0;
      mem_rdata  = rw;

      if (mis) begin
         @(negedge clk);
         check({tag, " mis_done"}, {31'b0, done}, 32'd1);
         check({tag, " mis_flag"}, {31'b0, misaligned}, 32'd1);
         check({tag, " mis_rdata"}, rdata, 32'h0);
         check({tag, " mis_memreq"}, {31'b0, mem_req}, 32'd0);
         check({tag, " mis_buserr"}, {31'b0, bus_err}, 32'd0);
      end else begin
         @(negedge clk);
         check({tag, " req"}, {31'b0, mem_req}, 32'd1);
         check({tag, " we"}, {31'b0, mem_we}, {31'b0, st});
         check({tag, " addr"}, {2'b0, mem_addr}, addr >> 2);
         check({tag, " stall"}, {31'b0, stall}, 32'd1);
         if (st) begin
            check({tag, " wstrb"}, {28'b0, mem_wstrb}, {28'b0, exp_strb});
            check({tag, " wdata"}, mem_wdata, exp_wdata);
         end
         for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check({tag, " hold_req"}, {31'b0, mem_req}, 32'd1);
            check({tag, " hold_addr"}, {2'b0, mem_addr}, addr >> 2);
            check({tag, " hold_stall"}, {31'b0, stall}, 32'd1);
            check({tag, " hold_done"}, {31'b0, done}, 32'd0);
         end
         mem_ready = 1'b1;
         @(negedge clk);
         mem_ready = 1'b0;
         check({tag, " done"}, {31'b0, done}, 32'd1);
         check({tag, " rdata"}, rdata, exp_rdata);
         check({tag, " misaligned"}, {31'b0, misaligned}, 32'd0);
         check({tag, " buserr"}, {31'b0, bus_err}, 32'd0);
         check({tag, " req_drop"}, {31'b0, mem_req}, 32'd0);
         check({tag, " stall_rel"}, {31'b0, stall}, 32'd0);
      end
      $display("txn %s: st=%0d f3=%0d addr=%h wd=%h rw=%h delay=%0d rdata=%h", tag, st, f3,
               addr, wd, rw, delay, rdata);
      req_valid = 1'b0;
      @(negedge clk);
      check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      logic [2:0] ld_f3 [5];
      ld_f3[0] = F3_B; ld_f3[1] = F3_H; ld_f3[2] = F3_W; ld_f3[3] = F3_BU; ld_f3[4] = F3_HU;

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_store  = 1'b0;
      req_funct3 = 3'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      mem_ready  = 1'b0;
      mem_rdata  = 32'h0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst mem_req", {31'b0, mem_req}, 32'd0);
      check("rst mem_we", {31'b0, mem_we}, 32'd0);
      check("rst done", {31'b0, done}, 32'd0);
      check("rst misaligned", {31'b0, misaligned}, 32'd0);
      check("rst bus_err", {31'b0, bus_err}, 32'd0);
      check("rst rdata", rdata, 32'h0);
      check("rst mem_addr", {2'b0, mem_addr}, 32'h0);
      check("rst mem_wdata", mem_wdata, 32'h0);
      check("rst mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases
      run_access("sw_10", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 0);
      run_access("lb_13", 1'b0, F3_B, 32'h13, 32'h0, 32'h80000000, 0);
      run_access("lbu_13", 1'b0, F3_BU, 32'h13, 32'h0, 32'h80000000, 0);
      run_access("sh_06", 1'b1, F3_H, 32'h6, 32'h1234, 32'h0, 0);
      run_access("lhu_02", 1'b0, F3_HU, 32'h2, 32'h0, 32'hABCD0000, 0);
      run_access("lh_05", 1'b0, F3_H, 32'h5, 32'h0, 32'hFFFFFFFF, 0);
      run_access("lw_06", 1'b0, F3_W, 32'h6, 32'h0, 32'h12345678, 0);
      run_access("lw_dly3", 1'b0, F3_W, 32'h100, 32'h0, 32'hCAFEF00D, 3);
      run_access("sb_03", 1'b1, F3_B, 32'h3, 32'h000000A5, 32'h0, 2);

      // Randomized accesses (delay stays below 4 so the watchdog build completes normally)
      for (int t = 0; t < 40; t++) begin
         logic        st;
         logic [2:0]  f3;
         st = 1'($urandom_range(0, 1));
         f3 = st ? ld_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
         run_access($sformatf("rnd%0d", t), st, f3, $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)));
      end

`ifdef LSU_TIMEOUT_EN
      // Memory never answers: bus error after TIMEOUT WAIT cycles
      req_valid  = 1'b1;
      req_store  = 1'b0;
      req_funct3 = F3_W;
      req_addr   = 32'h40;
      mem_ready  = 1'b0;
      @(negedge clk);
      for (int i = 1; i < TB_TIMEOUT; i++) begin
         check("to wait_req", {31'b0, mem_req}, 32'd1);
         check("to wait_done", {31'b0, done}, 32'd0);
         @(negedge clk);
      end
      check("to last_req", {31'b0, mem_req}, 32'd1);
      @(negedge clk);
      check("to done", {31'b0, done}, 32'd1);
      check("to bus_err", {31'b0, bus_err}, 32'd1);
      check("to misaligned", {31'b0, misaligned}, 32'd0);
      check("to rdata", rdata, 32'h0);
      check("to mem_req", {31'b0, mem_req}, 32'd0);
      $display("txn timeout: done=%0d bus_err=%0d", done, bus_err);
      req_valid = 1'b0;
      @(negedge clk);
      check("to done_pulse", {31'b0, done}, 32'd0);
`endif

      // Reset in the middle of WAIT: request drops at once, no done afterwards
      req_valid  = 1'b1;
      req_store  = 1'b0;
      req_funct3 = F3_W;
      req_addr   = 32'h80;
      mem_ready  = 1'b0;
      @(negedge clk);
      check("rstw req_before", {31'b0, mem_req}, 32'd1);
      rst_n     = 1'b0;
      req_valid = 1'b0;
      #1;
      check("rstw req_drop", {31'b0, mem_req}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rstw no_done", {31'b0, done}, 32'd0);
         check("rstw no_req", {31'b0, mem_req}, 32'd0);
      end
      $display("txn reset_mid_wait: mem_req=%0d done=%0d", mem_req, done);

      // Unit still works after the abandoned access
      run_access("post_rst_lh", 1'b0, F3_H, 32'h22, 32'h0, 32'h8001FFFF, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
